pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register for the five-stage CPU datapath. It replaces fixed per-stage register banks with one generic block: payload width is a parameter, stall is carried by a valid/ready handshake, and a two-entry skid buffer gives full throughput with a registered `in_ready`. Flush zeroes the stage, which inserts a NOP bubble. A saturating counter reports back-pressure cycles. It sits between any two pipeline stages, for example M→W.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 tb/tb_pipe_skid_reg.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage registers.
//   - EMPTY / ONE / FULL: state encodings, equal to the number of valid entries.
//   - state_t: enumerated state type built on those encodings.
//   - NOP_BIT: fill bit for the bubble payload. An all-zero instr decodes as a NOP.
package pipe_pkg;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = EMPTY,
    ST_ONE   = ONE,
    ST_FULL  = FULL
  } state_t;

  // Replicated to the payload width by each user; the payload width is a
  // per-instance parameter.
  localparam logic NOP_BIT = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that stops at its maximum value instead of wrapping.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears the count
//   inc   : count this cycle
//   count : current value, W bits, saturates at 2^W-1
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic pipeline stage register with a two-entry skid buffer.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high
//   flush     : synchronous clear of both entries, which inserts a NOP bubble
//   in_valid  / in_ready  / in_data  : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and payload
//   stall_cnt : saturating count of cycles with out_valid & !out_ready
//   dbg_state : current FSM state (EMPTY/ONE/FULL), for observation only
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A producer holds valid and data stable until that edge. in_ready is
// decoded from registered state only, so it never depends combinationally on
// out_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  localparam logic [DATA_W-1:0] NOP = {DATA_W{NOP_BIT}};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign out_data  = main_q;
  assign dbg_state = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP;
      skid_q  <= NOP;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain can happen.
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    // Flush overrides every handshake. A beat accepted in the same cycle is
    // dropped, because the upstream stage is flushed as well.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP;
      skid_d  = NOP;
    end
  end

  // The count uses the pre-flush outputs, so a stalled flush cycle still counts.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    dbg_state;

  // Small instance used for the counter saturation check.
  logic       d3_flush = 1'b0;
  logic       d3_in_valid = 1'b0;
  logic       d3_in_ready;
  logic [7:0] d3_in_data = '0;
  logic       d3_out_valid;
  logic       d3_out_ready = 1'b0;
  logic [7:0] d3_out_data;
  logic [2:0] d3_stall_cnt;
  logic [1:0] d3_dbg_state;

  pipe_skid_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  pipe_skid_reg #(.DATA_W(8), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .flush(d3_flush),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_data(d3_in_data),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_data(d3_out_data),
    .stall_cnt(d3_stall_cnt), .dbg_state(d3_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_data = '0;
  int            cnt_model = 0;
  bit            mon_en = 1'b0;
  int            n_vec = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the falling edge. At +3 the driver
  // records an accepted beat in the expected queue (the monitor has already
  // examined this cycle at +2).
  task automatic drive(input bit v, input logic [DW-1:0] d, input bit ordy, input bit fl);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #2;
    if (in_valid && in_ready && !flush) exp_q.push_back(in_data);
  endtask

  // ---------------- monitor ----------------
  // The model is a FIFO of at most two beats. Occupancy gives valid/ready,
  // and the head gives the output data. When the FIFO is empty, the output
  // data is the last beat delivered, or zero after reset or flush.
  always begin
    int occ;
    @(negedge clk);
    #2;
    if (mon_en) begin
      occ = exp_q.size();
      chk("out_valid", 64'(out_valid), 64'(occ != 0));
      chk("in_ready", 64'(in_ready), 64'(occ < 2));
      chk("stall_cnt", 64'(stall_cnt), 64'(cnt_model));
      if (occ != 0) chk("out_data", 64'(out_data), 64'(exp_q[0]));
      else          chk("out_data_hold", 64'(out_data), 64'(last_data));
      if (occ != 0 && !out_ready && cnt_model < (2**CW - 1)) cnt_model++;
      if (flush) begin
        exp_q.delete();
        last_data = '0;
      end else if (occ != 0 && out_ready) begin
        last_data = exp_q.pop_front();
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    #3 reset = 1'b0;
    mon_en = 1'b1;

    // streaming
    drive(1, 32'h11, 1, 0);
    drive(1, 32'h22, 1, 0);
    drive(1, 32'h33, 1, 0);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);

    // stall / skid
    drive(1, 32'hA, 1, 0);
    drive(1, 32'hB, 0, 0);
    drive(0, 32'h0, 0, 0);
    drive(0, 32'h0, 0, 0);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);

    // flush while full, with a beat presented
    drive(1, 32'hD, 0, 0);
    drive(1, 32'hE, 0, 0);
    drive(1, 32'hC, 0, 1);
    drive(0, 32'h0, 1, 0);
    // flush while holding one beat, with a beat that would be accepted
    drive(1, 32'h5, 1, 0);
    drive(1, 32'hC, 0, 1);
    drive(0, 32'h0, 1, 0);

    // asynchronous reset mid-operation while full
    drive(1, 32'h71, 0, 0);
    drive(1, 32'h72, 0, 0);
    @(negedge clk);
    #3;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    exp_q.delete();
    last_data = '0;
    cnt_model = 0;
    @(negedge clk);
    #3 reset = 1'b0;
    mon_en = 1'b1;

    // counter: five stalled cycles
    drive(1, 32'h7, 0, 0);
    repeat (5) drive(0, 32'h0, 0, 0);
    @(negedge clk);
    #2 chk("stall_cnt_5", 64'(stall_cnt), 64'd5);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);

    // randomised traffic with occasional flush
    for (int i = 0; i < 10000; i++) begin
      drive(bit'($urandom_range(0, 1)), DW'($urandom),
            bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 63) == 0));
    end
    repeat (4) drive(0, 32'h0, 1, 0);
    chk("drained", 64'(exp_q.size()), 64'd0);

    // saturation on the 3-bit counter, and flush leaving it unchanged
    @(negedge clk);
    #1;
    d3_in_valid = 1'b1;
    d3_in_data = 8'h5A;
    d3_out_ready = 1'b0;
    @(negedge clk);
    #1 d3_in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    chk("d3_stall_sat", 64'(d3_stall_cnt), 64'd7);
    chk("d3_out_data", 64'(d3_out_data), 64'h5A);
    chk("d3_out_valid", 64'(d3_out_valid), 64'd1);
    #1 d3_flush = 1'b1;
    @(negedge clk);
    #1 d3_flush = 1'b0;
    #1;
    chk("d3_flush_cnt", 64'(d3_stall_cnt), 64'd7);
    chk("d3_flush_valid", 64'(d3_out_valid), 64'd0);
    chk("d3_flush_data", 64'(d3_out_data), 64'd0);
    chk("d3_flush_ready", 64'(d3_in_ready), 64'd1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
